// File: rtl/serial_pkg.sv
// Shared types and constants for the serial_port UART peripheral.
package serial_pkg;

  localparam int unsigned DATA_BITS            = 8;
  localparam int unsigned DEFAULT_CLKS_PER_BIT = 434;

  typedef enum logic [1:0] {
    TX_IDLE,
    TX_START,
    TX_DATA,
    TX_STOP
  } tx_state_e;

  typedef enum logic [2:0] {
    RX_IDLE,
    RX_START,
    RX_DATA,
    RX_STOP,
    RX_WAIT_IDLE
  } rx_state_e;

endpackage

// File: rtl/byte_fifo.sv
// Byte-wide synchronous FIFO with show-ahead head and registered pointers/count.
module byte_fifo
  import serial_pkg::*;
#(
  parameter int unsigned DEPTH = 16
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 push,
  input  logic                 pop,
  input  logic [DATA_BITS-1:0] data_in,
  output logic [DATA_BITS-1:0] data_out,
  output logic                 full,
  output logic                 empty
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;

  logic [DATA_BITS-1:0] mem_q [DEPTH];
  logic [AW-1:0]        wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]        rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]        count_q, count_d;
  logic                 do_push, do_pop;

  assign full    = (count_q == CW'(DEPTH));
  assign empty   = (count_q == '0);
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;

  // Head is forced to zero while empty so the output is defined straight out of reset.
  assign data_out = empty ? '0 : mem_q[rd_ptr_q];

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_push) wr_ptr_d = wr_ptr_q + AW'(1);
    if (do_pop)  rd_ptr_d = rd_ptr_q + AW'(1);
    if (do_push && !do_pop)      count_d = count_q + CW'(1);
    else if (!do_push && do_pop) count_d = count_q - CW'(1);
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clock) begin
    if (do_push) mem_q[wr_ptr_q] <= data_in;
  end

endmodule

// File: rtl/serial_port.sv
// 8N1 UART peripheral with RX/TX byte FIFOs on a processor serial handshake.
// Define SERIAL_PORT_LOOPBACK_EN to feed the transmitter back into the receiver.
module serial_port
  import serial_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT,
  parameter int unsigned FIFO_DEPTH   = 16
) (
  input  logic       clock,
  input  logic       reset,
  input  logic [7:0] cpu_data_in,
  input  logic       cpu_wren_in,
  input  logic       cpu_rden_in,
  output logic [7:0] cpu_data_out,
  output logic       cpu_valid_out,
  output logic       cpu_ready_out,
  input  logic       uart_rx_in,
  output logic       uart_tx_out,
  output logic       rx_overrun_out,
  output logic       rx_frame_err_out
);

  localparam int unsigned CW = $clog2(CLKS_PER_BIT);
  localparam int unsigned BW = $clog2(DATA_BITS);
  localparam logic [CW-1:0] CNT_LAST = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] CNT_HALF = CW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [BW-1:0] BIT_LAST = BW'(DATA_BITS - 1);

  logic                 tx_full, tx_empty, tx_pop;
  logic [DATA_BITS-1:0] tx_head;
  logic                 rx_full, rx_empty, rx_push;

  tx_state_e            tx_state_q, tx_state_d;
  logic [CW-1:0]        tx_cnt_q, tx_cnt_d;
  logic [BW-1:0]        tx_bit_q, tx_bit_d;
  logic [DATA_BITS-1:0] tx_shift_q, tx_shift_d;
  logic                 tx_q, tx_d;

  rx_state_e            rx_state_q, rx_state_d;
  logic [CW-1:0]        rx_cnt_q, rx_cnt_d;
  logic [BW-1:0]        rx_bit_q, rx_bit_d;
  logic [DATA_BITS-1:0] rx_shift_q, rx_shift_d;
  logic                 ovr_q, ovr_d, ferr_q, ferr_d;
  logic [1:0]           sync_q;
  logic                 rx_src, rx_s;

  byte_fifo #(.DEPTH(FIFO_DEPTH)) u_tx_fifo (
    .clock(clock), .reset(reset), .push(cpu_wren_in), .pop(tx_pop),
    .data_in(cpu_data_in), .data_out(tx_head), .full(tx_full), .empty(tx_empty)
  );

  byte_fifo #(.DEPTH(FIFO_DEPTH)) u_rx_fifo (
    .clock(clock), .reset(reset), .push(rx_push), .pop(cpu_rden_in),
    .data_in(rx_shift_q), .data_out(cpu_data_out), .full(rx_full), .empty(rx_empty)
  );

  assign cpu_valid_out    = ~rx_empty;
  assign cpu_ready_out    = ~tx_full;
  assign uart_tx_out      = tx_q;
  assign rx_overrun_out   = ovr_q;
  assign rx_frame_err_out = ferr_q;

`ifdef SERIAL_PORT_LOOPBACK_EN
  logic unused_rx;
  assign unused_rx = uart_rx_in;
  assign rx_src    = tx_q;
`else
  assign rx_src = uart_rx_in;
`endif

  assign rx_s = sync_q[1];

  // tx_d is the line level for the state being entered, so the output stays registered.
  always_comb begin
    tx_state_d = tx_state_q;
    tx_cnt_d   = tx_cnt_q + CW'(1);
    tx_bit_d   = tx_bit_q;
    tx_shift_d = tx_shift_q;
    tx_d       = tx_q;
    tx_pop     = 1'b0;
    unique case (tx_state_q)
      TX_IDLE: begin
        tx_cnt_d = '0;
        if (!tx_empty) begin
          tx_pop     = 1'b1;
          tx_shift_d = tx_head;
          tx_state_d = TX_START;
          tx_d       = 1'b0;
        end
      end
      TX_START: begin
        if (tx_cnt_q == CNT_LAST) begin
          tx_cnt_d   = '0;
          tx_bit_d   = '0;
          tx_state_d = TX_DATA;
          tx_d       = tx_shift_q[0];
        end
      end
      TX_DATA: begin
        if (tx_cnt_q == CNT_LAST) begin
          tx_cnt_d = '0;
          if (tx_bit_q == BIT_LAST) begin
            tx_state_d = TX_STOP;
            tx_d       = 1'b1;
          end else begin
            tx_bit_d   = tx_bit_q + BW'(1);
            tx_shift_d = tx_shift_q >> 1;
            tx_d       = tx_shift_q[1];
          end
        end
      end
      TX_STOP: begin
        if (tx_cnt_q == CNT_LAST) begin
          tx_cnt_d = '0;
          if (!tx_empty) begin
            tx_pop     = 1'b1;
            tx_shift_d = tx_head;
            tx_state_d = TX_START;
            tx_d       = 1'b0;
          end else begin
            tx_state_d = TX_IDLE;
            tx_d       = 1'b1;
          end
        end
      end
      default: tx_state_d = TX_IDLE;
    endcase
  end

  always_comb begin
    rx_state_d = rx_state_q;
    rx_cnt_d   = rx_cnt_q + CW'(1);
    rx_bit_d   = rx_bit_q;
    rx_shift_d = rx_shift_q;
    ovr_d      = ovr_q;
    ferr_d     = ferr_q;
    rx_push    = 1'b0;
    unique case (rx_state_q)
      RX_IDLE: begin
        rx_cnt_d = '0;
        if (!rx_s) rx_state_d = RX_START;
      end
      RX_START: begin
        if (rx_cnt_q == CNT_HALF) begin
          rx_cnt_d   = '0;
          rx_bit_d   = '0;
          rx_state_d = rx_s ? RX_IDLE : RX_DATA;
        end
      end
      RX_DATA: begin
        if (rx_cnt_q == CNT_LAST) begin
          rx_cnt_d   = '0;
          rx_shift_d = {rx_s, rx_shift_q[DATA_BITS-1:1]};
          if (rx_bit_q == BIT_LAST) rx_state_d = RX_STOP;
          else                      rx_bit_d   = rx_bit_q + BW'(1);
        end
      end
      RX_STOP: begin
        if (rx_cnt_q == CNT_LAST) begin
          rx_cnt_d = '0;
          if (rx_s) begin
            rx_push    = 1'b1;
            ovr_d      = ovr_q | rx_full;
            rx_state_d = RX_IDLE;
          end else begin
            ferr_d     = 1'b1;
            rx_state_d = RX_WAIT_IDLE;
          end
        end
      end
      RX_WAIT_IDLE: begin
        rx_cnt_d = '0;
        if (rx_s) rx_state_d = RX_IDLE;
      end
      default: rx_state_d = RX_IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      tx_state_q <= TX_IDLE;
      tx_cnt_q   <= '0;
      tx_bit_q   <= '0;
      tx_shift_q <= '0;
      tx_q       <= 1'b1;
      rx_state_q <= RX_IDLE;
      rx_cnt_q   <= '0;
      rx_bit_q   <= '0;
      rx_shift_q <= '0;
      ovr_q      <= 1'b0;
      ferr_q     <= 1'b0;
      sync_q     <= '1;
    end else begin
      tx_state_q <= tx_state_d;
      tx_cnt_q   <= tx_cnt_d;
      tx_bit_q   <= tx_bit_d;
      tx_shift_q <= tx_shift_d;
      tx_q       <= tx_d;
      rx_state_q <= rx_state_d;
      rx_cnt_q   <= rx_cnt_d;
      rx_bit_q   <= rx_bit_d;
      rx_shift_q <= rx_shift_d;
      ovr_q      <= ovr_d;
      ferr_q     <= ferr_d;
      sync_q     <= {sync_q[0], rx_src};
    end
  end

endmodule

// File: tb/tb_serial_port.sv
// Directed self-checking bench for serial_port at CLKS_PER_BIT = 4, FIFO_DEPTH = 16.
module tb_serial_port;

  localparam int unsigned CPB = 4;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic [7:0] cpu_data_in = '0;
  logic       cpu_wren_in = 1'b0;
  logic       cpu_rden_in = 1'b0;
  logic [7:0] cpu_data_out;
  logic       cpu_valid_out;
  logic       cpu_ready_out;
  logic       uart_rx_in = 1'b1;
  logic       uart_tx_out;
  logic       rx_overrun_out;
  logic       rx_frame_err_out;

  int unsigned n_checks = 0;
  int unsigned n_fail   = 0;

  serial_port #(.CLKS_PER_BIT(CPB), .FIFO_DEPTH(16)) dut (
    .clock(clock), .reset(reset),
    .cpu_data_in(cpu_data_in), .cpu_wren_in(cpu_wren_in), .cpu_rden_in(cpu_rden_in),
    .cpu_data_out(cpu_data_out), .cpu_valid_out(cpu_valid_out), .cpu_ready_out(cpu_ready_out),
    .uart_rx_in(uart_rx_in), .uart_tx_out(uart_tx_out),
    .rx_overrun_out(rx_overrun_out), .rx_frame_err_out(rx_frame_err_out)
  );

  always #5 clock = ~clock;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic tick(input int unsigned n = 1);
    repeat (n) begin
      @(posedge clock);
      #1;
    end
  endtask

  task automatic do_reset();
    reset = 1'b1;
    tick(3);
    reset = 1'b0;
  endtask

  task automatic check_reset_outputs(input string tag);
    check_eq({tag, "_valid"}, cpu_valid_out, 1'b0);
    check_eq({tag, "_ready"}, cpu_ready_out, 1'b1);
    check_eq({tag, "_data"}, cpu_data_out, 8'h00);
    check_eq({tag, "_tx"}, uart_tx_out, 1'b1);
    check_eq({tag, "_ovr"}, rx_overrun_out, 1'b0);
    check_eq({tag, "_ferr"}, rx_frame_err_out, 1'b0);
  endtask

  task automatic send_frame(input logic [7:0] b, input logic stop_bit);
    uart_rx_in = 1'b0;
    tick(CPB);
    for (int i = 0; i < 8; i++) begin
      uart_rx_in = b[i];
      tick(CPB);
    end
    uart_rx_in = stop_bit;
    tick(CPB);
    uart_rx_in = 1'b1;
  endtask

  // Waits for a start bit on uart_tx_out, then samples each bit near its centre.
  task automatic capture_tx(output logic [7:0] b, output logic ok);
    int unsigned waited = 0;
    b  = '0;
    ok = 1'b1;
    while (uart_tx_out !== 1'b0 && waited < 400) begin
      tick();
      waited++;
    end
    if (uart_tx_out !== 1'b0) begin
      ok = 1'b0;
      return;
    end
    tick(1);
    for (int i = 0; i < 8; i++) begin
      tick(CPB);
      b[i] = uart_tx_out;
    end
    tick(CPB);
    check_eq("tx_stop_bit", uart_tx_out, 1'b1);
  endtask

  initial begin
    logic [9:0] frame_a5;
    logic [7:0] tx_bytes [18];
    int unsigned waited;

    do_reset();
    check_reset_outputs("reset");

`ifdef SERIAL_PORT_LOOPBACK_EN
    cpu_data_in = 8'h5A;
    cpu_wren_in = 1'b1;
    tick();
    cpu_wren_in = 1'b0;
    waited = 0;
    while (cpu_valid_out !== 1'b1 && waited < 100) begin
      tick();
      waited++;
    end
    check_eq("lb_valid", cpu_valid_out, 1'b1);
    check_eq("lb_data", cpu_data_out, 8'h5A);
    check_eq("lb_latency_bound", (waited >= 40 && waited <= 50), 1'b1);
    cpu_rden_in = 1'b1;
    tick();
    cpu_rden_in = 1'b0;
    check_eq("lb_popped", cpu_valid_out, 1'b0);

    cpu_data_in = 8'hC3;
    cpu_wren_in = 1'b1;
    tick();
    cpu_wren_in = 1'b0;
    tick(15);
    check_eq("lb_midframe_low", uart_tx_out, 1'b0);
    reset = 1'b1;
    tick();
    check_reset_outputs("lb_midreset");
    reset = 1'b0;
    tick(60);
    check_eq("lb_no_partial", cpu_valid_out, 1'b0);
    check_eq("lb_tx_idle", uart_tx_out, 1'b1);
`else
    // TX of 0xA5: start, LSB-first data, stop; each level for CPB cycles.
    frame_a5 = {1'b1, 8'hA5, 1'b0};
    cpu_data_in = 8'hA5;
    cpu_wren_in = 1'b1;
    tick();
    cpu_wren_in = 1'b0;
    check_eq("tx_still_idle_at_e", uart_tx_out, 1'b1);
    check_eq("tx_fifo_visible", cpu_ready_out, 1'b1);
    tick();
    for (int b = 0; b < 10; b++) begin
      for (int c = 0; c < int'(CPB); c++) begin
        check_eq($sformatf("tx_a5_bit%0d", b), uart_tx_out, frame_a5[b]);
        tick();
      end
    end
    for (int c = 0; c < 5; c++) begin
      check_eq("tx_idle_after", uart_tx_out, 1'b1);
      tick();
    end

    // RX glitch, good frame, pop.
    do_reset();
    uart_rx_in = 1'b0;
    tick();
    uart_rx_in = 1'b1;
    tick(20);
    check_eq("glitch_no_push", cpu_valid_out, 1'b0);
    check_eq("glitch_no_ferr", rx_frame_err_out, 1'b0);
    check_eq("glitch_no_ovr", rx_overrun_out, 1'b0);

    send_frame(8'h3C, 1'b1);
    check_eq("rx_not_yet", cpu_valid_out, 1'b0);
    tick(2);
    check_eq("rx_valid", cpu_valid_out, 1'b1);
    check_eq("rx_data", cpu_data_out, 8'h3C);
    cpu_rden_in = 1'b1;
    tick();
    cpu_rden_in = 1'b0;
    check_eq("rx_popped", cpu_valid_out, 1'b0);
    check_eq("rx_popped_data", cpu_data_out, 8'h00);

    // Stop bit sampled low.
    send_frame(8'h55, 1'b0);
    tick(3);
    check_eq("ferr_set", rx_frame_err_out, 1'b1);
    check_eq("ferr_no_push", cpu_valid_out, 1'b0);
    check_eq("ferr_no_ovr", rx_overrun_out, 1'b0);
    tick(50);
    check_eq("ferr_sticky", rx_frame_err_out, 1'b1);
    send_frame(8'h81, 1'b1);
    tick(2);
    check_eq("ferr_recover_valid", cpu_valid_out, 1'b1);
    check_eq("ferr_recover_data", cpu_data_out, 8'h81);
    check_eq("ferr_still_sticky", rx_frame_err_out, 1'b1);
    do_reset();
    check_eq("ferr_cleared", rx_frame_err_out, 1'b0);
    check_eq("fifo_cleared", cpu_valid_out, 1'b0);

    // TX full: 18 back-to-back writes, 17 frames expected on the line.
    do_reset();
    for (int k = 0; k < 18; k++) tx_bytes[k] = 8'(k * 37 + 11);
    fork
      begin
        for (int k = 0; k < 18; k++) begin
          check_eq($sformatf("ready_before_wr%0d", k), cpu_ready_out, (k < 17));
          cpu_data_in = tx_bytes[k];
          cpu_wren_in = 1'b1;
          tick();
        end
        cpu_wren_in = 1'b0;
        check_eq("ready_full", cpu_ready_out, 1'b0);
      end
      begin
        logic [7:0] got;
        logic       ok;
        for (int k = 0; k < 17; k++) begin
          capture_tx(got, ok);
          check_eq($sformatf("tx_cap_ok%0d", k), ok, 1'b1);
          check_eq($sformatf("tx_cap_byte%0d", k), got, tx_bytes[k]);
        end
      end
    join
    waited = 0;
    for (int c = 0; c < 100; c++) begin
      if (uart_tx_out !== 1'b1) waited++;
      tick();
    end
    check_eq("tx_18th_dropped", waited, 0);
    check_eq("tx_ready_drained", cpu_ready_out, 1'b1);

    // Overrun: 17 frames into a 16-deep RX FIFO.
    do_reset();
    for (int k = 0; k < 16; k++) begin
      send_frame(8'(k), 1'b1);
      tick(3);
    end
    check_eq("ovr_not_yet", rx_overrun_out, 1'b0);
    send_frame(8'h10, 1'b1);
    tick(3);
    check_eq("ovr_set", rx_overrun_out, 1'b1);
    check_eq("ovr_head", cpu_data_out, 8'h00);
    check_eq("ovr_no_ferr", rx_frame_err_out, 1'b0);
    for (int k = 0; k < 16; k++) begin
      check_eq($sformatf("ovr_valid%0d", k), cpu_valid_out, 1'b1);
      check_eq($sformatf("ovr_entry%0d", k), cpu_data_out, 8'(k));
      cpu_rden_in = 1'b1;
      tick();
    end
    cpu_rden_in = 1'b0;
    check_eq("ovr_0x10_absent", cpu_valid_out, 1'b0);
    check_eq("ovr_sticky", rx_overrun_out, 1'b1);
    cpu_rden_in = 1'b1;
    tick();
    cpu_rden_in = 1'b0;
    check_eq("pop_empty_ignored", cpu_valid_out, 1'b0);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
